// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bus of the seven-segment scan controller: the value and
// mask inputs from the register block, and the pin outputs toward the display.
interface seven_seg_scan_ctrl_if;
    logic [31:0] disp_num;
    logic        load;
    logic [7:0]  blank_mask;
    logic [7:0]  point;
    logic [7:0]  blink_en;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    // Register-block side: drives value and masks, observes the pins.
    modport master (
        output disp_num, load, blank_mask, point, blink_en,
        input  an, seg, frame_done
    );

    // Controller side.
    modport slave (
        input  disp_num, load, blank_mask, point, blink_en,
        output an, seg, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode seven-segment scan controller.
// Each digit slot starts with a short all-off guard to avoid ghosting. The
// displayed value is swapped only at frame wrap so a frame never mixes
// old and new nibbles. Per-digit blank, decimal point and blink apply live.

// One digit lane: hex decode plus the per-digit dark condition (excluding
// the guard interval, which is common to all digits).
module seven_seg_lane (
    input  logic [3:0] nib_i,
    input  logic       point_i,
    input  logic       blank_i,
    input  logic       blink_i,
    input  logic       blink_phase_i,
    output logic [7:0] seg_o,
    output logic       dark_o
);
    logic [6:0] hex;

    // Hex to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        hex = 7'h7F;
        case (nib_i)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end

    assign seg_o  = {~point_i, hex};
    assign dark_o = blank_i | (blink_i & blink_phase_i);
endmodule

module seven_seg_scan_ctrl #(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned GUARD        = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_ctrl_if.slave  bus
);
    localparam int NUM_DIG = 8;
    localparam int NIB_W   = 4;
    localparam int CNT_W   = 16;
    localparam int DIG_W   = 3;
    localparam int FRM_W   = 8;
    localparam logic [NUM_DIG*NIB_W-1:0] SHADOW_RST = 32'hAA5555AA;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DIG_W-1:0]         d_q, d_d;
    logic [NUM_DIG*NIB_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIG*NIB_W-1:0] pending_q, pending_d;
    logic                     pend_v_q, pend_v_d;
    logic [FRM_W-1:0]         fcnt_q, fcnt_d;
    logic                     phase_q, phase_d;
    logic [NUM_DIG-1:0]       an_q, an_d;
    logic [7:0]               seg_q, seg_d;
    logic                     fd_q;

    logic                     slot_end;
    logic                     wrap;
    logic                     cur_dark;
    logic [NUM_DIG-1:0][7:0]  lane_seg;
    logic [NUM_DIG-1:0]       lane_dark;

    assign slot_end = (cnt_q == CNT_W'(PRESCALE - 1));
    assign wrap     = slot_end && (d_q == DIG_W'(NUM_DIG - 1));

    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_lane
            seven_seg_lane u_lane (
                .nib_i         (shadow_q[g*NIB_W +: NIB_W]),
                .point_i       (bus.point[g]),
                .blank_i       (bus.blank_mask[g]),
                .blink_i       (bus.blink_en[g]),
                .blink_phase_i (phase_q),
                .seg_o         (lane_seg[g]),
                .dark_o        (lane_dark[g])
            );
        end
    endgenerate

    // Slot counter and digit index; digit advances when a slot expires.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        d_d   = d_q;
        if (slot_end) begin
            cnt_d = '0;
            d_d   = d_q + DIG_W'(1);
        end
    end

    // Capture: load goes to pending; shadow swaps only at wrap, a load on
    // the wrap cycle itself bypasses pending.
    always_comb begin
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        shadow_d  = shadow_q;
        if (bus.load) begin
            pending_d = bus.disp_num;
            pend_v_d  = 1'b1;
        end
        if (wrap) begin
            pend_v_d = 1'b0;
            if (bus.load)
                shadow_d = bus.disp_num;
            else if (pend_v_q)
                shadow_d = pending_q;
        end
    end

    // Blink phase toggles on the wrap that completes BLINK_FRAMES frames.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (fcnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FRM_W'(1);
            end
        end
    end

    // Next pin values for the current digit; guard interval forces dark.
    always_comb begin
        cur_dark = (cnt_q < CNT_W'(GUARD)) || lane_dark[d_q];
        an_d     = '1;
        seg_d    = '1;
        if (!cur_dark) begin
            an_d  = ~(NUM_DIG'(1) << d_q);
            seg_d = lane_seg[d_q];
        end
    end

    // State and registered outputs; async reset blanks the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            d_q       <= '0;
            shadow_q  <= SHADOW_RST;
            pending_q <= '0;
            pend_v_q  <= 1'b0;
            fcnt_q    <= '0;
            phase_q   <= 1'b0;
            an_q      <= '1;
            seg_q     <= '1;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            fcnt_q    <= fcnt_d;
            phase_q   <= phase_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            fd_q      <= wrap;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with PRESCALE=8, GUARD=2,
// BLINK_FRAMES=2: every cycle of each frame is compared against
// hand-derived pin values.
module tb_seven_seg_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fr;

    seven_seg_scan_ctrl_if bus ();

    seven_seg_scan_ctrl #(
        .PRESCALE     (8),
        .GUARD        (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Active-low segment patterns {g..a} from the display datasheet table.
    function automatic logic [6:0] hexseg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the sample point right after a frame boundary (or reset
    // release). Sample k reflects scan position k-1 of this frame.
    // Optional load pulses are placed at samples k1/k2 (-1 = none).
    task automatic check_frame(input logic [31:0] val, input logic [7:0] bm,
                               input logic [7:0] pt, input logic [7:0] be,
                               input int k1, input logic [31:0] v1,
                               input int k2, input logic [31:0] v2);
        logic       ph;
        logic [7:0] ea, es;
        logic [3:0] nib;
        int         p, c, dd;
        ph = ((fr / 2) % 2) == 1;
        bus.blank_mask = bm;
        bus.point      = pt;
        bus.blink_en   = be;
        for (int k = 1; k <= 64; k++) begin
            tick();
            p  = k - 1;
            c  = p % 8;
            dd = p / 8;
            nib = val[dd*4 +: 4];
            if (c < 2 || bm[dd] || (be[dd] && ph)) begin
                ea = 8'hFF;
                es = 8'hFF;
            end else begin
                ea = ~(8'h01 << dd);
                es = {~pt[dd], hexseg(nib)};
            end
            chk($sformatf("f%0d_k%0d", fr, k),
                {15'd0, bus.frame_done, bus.an, bus.seg},
                {15'd0, (k == 64), ea, es});
            bus.load = 1'b0;
            if (k == k1) begin
                bus.load = 1'b1;
                bus.disp_num = v1;
            end else if (k == k2) begin
                bus.load = 1'b1;
                bus.disp_num = v2;
            end
        end
        fr++;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.disp_num   = '0;
        bus.load       = 1'b0;
        bus.blank_mask = '0;
        bus.point      = '0;
        bus.blink_en   = '0;
        repeat (3) tick();
        chk("rst_pins", {15'd0, bus.frame_done, bus.an, bus.seg}, 32'h0000FFFF);
        rst_n = 1'b1;
        fr = 0;

        // Reset sequence: reset value AA5555AA, guard then digit 0.
        check_frame(32'hAA5555AA, 8'h00, 8'h00, 8'h00, -1, 0, -1, 0);
        // Mid-frame load is held off until the wrap.
        check_frame(32'hAA5555AA, 8'h00, 8'h00, 8'h00, 20, 32'h01234567, -1, 0);
        // Two loads in one frame: last one wins.
        check_frame(32'h01234567, 8'h00, 8'h00, 8'h00, 10, 32'h11111111, 30, 32'h22222222);
        // Load on the wrap cycle goes straight to the next frame.
        check_frame(32'h22222222, 8'h00, 8'h00, 8'h00, 63, 32'h33333333, -1, 0);
        // Blank digit 7, decimal point on digit 0.
        check_frame(32'h33333333, 8'h80, 8'h01, 8'h00, -1, 0, -1, 0);
        check_frame(32'h33333333, 8'h80, 8'h01, 8'h00, -1, 0, -1, 0);

        // Reset mid-frame with a pending value queued while digit 5 scans.
        bus.blank_mask = '0;
        bus.point      = '0;
        for (int k = 1; k <= 44; k++) begin
            tick();
            bus.load = (k == 10);
            if (k == 10) bus.disp_num = 32'hDEADBEEF;
        end
        chk("pre_rst_an", {24'd0, bus.an}, 32'h000000DF);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {15'd0, bus.frame_done, bus.an, bus.seg}, 32'h0000FFFF);
        repeat (3) tick();
        chk("rst_hold", {15'd0, bus.frame_done, bus.an, bus.seg}, 32'h0000FFFF);
        rst_n = 1'b1;
        fr = 0;

        // Pending value discarded; blink digit 1 from a fresh reset.
        for (int f = 0; f < 6; f++)
            check_frame(32'hAA5555AA, 8'h00, 8'h00, 8'h02, -1, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
